uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular-buffer FIFO that feeds a UartTx one word at a time.
//
// Ports:
//   i_clk            clock, all state changes on the rising edge
//   i_reset          asynchronous active-low reset
//   iv_data          word to enqueue, sampled when i_write=1
//   i_write          write strobe
//   o_full           count == 2**DEPTH_LOG2
//   o_empty          count == 0
//   ov_count         number of words stored
//   o_overflow       one-cycle pulse after a write was dropped on a full FIFO
//   ov_tx_data       registered data word to UartTx
//   o_tx_data_ready  registered one-cycle strobe to UartTx
//   i_tx_busy        UartTx busy flag
module uart_tx_fifo #(
  parameter int unsigned WIDTH_DATA   = 8,
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [WIDTH_DATA-1:0] iv_data,
  input  logic                  i_write,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   ov_count,
  output logic                  o_overflow,
  output logic [WIDTH_DATA-1:0] ov_tx_data,
  output logic                  o_tx_data_ready,
  input  logic                  i_tx_busy
);

  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
  localparam int unsigned TimerW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [DEPTH_LOG2:0] FullCount = Depth[DEPTH_LOG2:0];
  localparam logic [TimerW-1:0]   TimerLast = TimerW'(BUSY_TIMEOUT - 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StIssue    = 2'd1;
  localparam logic [1:0] StWaitBusy = 2'd2;
  localparam logic [1:0] StWaitDone = 2'd3;

  logic [WIDTH_DATA-1:0] mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  overflow_q;
  logic                  tx_ready_q;
  logic [WIDTH_DATA-1:0] tx_data_q;
  logic [1:0]            state_q, state_d;
  logic [TimerW-1:0]     timer_q, timer_d;

  logic full, empty, push, pop;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign push  = i_write & ~full;
  // Popping the head is what moves the FSM from idle into issue.
  assign pop   = (state_q == StIdle) & ~empty & ~i_tx_busy;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        if (pop) state_d = StIssue;
      end
      StIssue: begin
        state_d = StWaitBusy;
        timer_d = '0;
      end
      StWaitBusy: begin
        if (i_tx_busy) begin
          state_d = StWaitDone;
        end else if (timer_q == TimerLast) begin
          // Transmitter never acknowledged; treat the word as sent.
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!i_tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_data_q  <= '0;
      state_q    <= StIdle;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      overflow_q <= i_write & full;
      tx_ready_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        tx_data_q <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only read below count.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= iv_data;
  end

  assign o_full          = full;
  assign o_empty         = empty;
  assign ov_count        = count_q;
  assign o_overflow      = overflow_q;
  assign ov_tx_data      = tx_data_q;
  assign o_tx_data_ready = tx_ready_q;

endmodule
